addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares the single 16-bit CLA add/sub unit (cla_16bit) between two requesters, e.g. the PC/branch-target path and the ALU/address-generation path.
- Each requester uses a valid/ready handshake. The arbiter grants round-robin and registers the operands. It drives cla_16bit, registers the result plus flags, and returns them with a one-cycle response pulse to the granted requester.
- A lock option gives one requester back-to-back exclusive access.

Parameters:
- WIDTH, 16, operand/result width. Must match cla_16bit; only 16 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accepted this cycle when valid&ready
- req0_a, req0_b  in  16 each  operands
- req0_sub  in  1  1 = A-B, 0 = A+B
- req0_lock  in  1  keep grant for requester 0 after this op
- req1_valid, req1_ready, req1_a, req1_b, req1_sub, req1_lock  same as requester 0, for requester 1
- resp0_valid  out  1  one-cycle pulse: result belongs to requester 0
- resp1_valid  out  1  one-cycle pulse: result belongs to requester 1
- result  out  16  registered sum/difference
- cout  out  1  registered carry-out from cla_16bit
- ovfl  out  1  registered signed overflow
- zero  out  1  registered result==0

Behaviour:
- Reset (async, rst_n=0) clears all outputs to 0 and sets state=IDLE. Round-robin pointer favours requester 0. Lock is cleared.
- FSM states:
  - IDLE: ready available.
  - EXEC: operand registers drive cla_16bit.
  - DONE: result registered, resp pulse high.
- Grant in IDLE or DONE:
  - Only one of reqX_ready is high in any cycle.
  - If lock is held by X, only reqX_ready may be high.
  - Otherwise, with a single valid, that requester gets ready.
  - With both valid, the requester not granted last gets ready.
  - With none valid, both readys stay 0.
- Readys are combinational from valids, state and pointer. No ready in EXEC.
- Handshake (valid&ready) in cycle t:
  - Latch a, b, sub, lock and the requester id.
  - Update the pointer.
  - Enter EXEC at t+1.
  - At the edge ending t+1, register result/cout/ovfl/zero and enter DONE. respX_valid=1 during t+2 only.
- In DONE a new handshake can occur, which goes to EXEC. Otherwise go to IDLE. Peak throughput is one op per 2 cycles.
- result/cout/ovfl/zero hold their last values until the next DONE update.
- ovfl:
  - add: a[15]==b[15] and result[15]!=a[15].
  - sub: a[15]!=b[15] and result[15]!=a[15].
- cout is passed through unmodified from cla_16bit. For subtraction, cout=1 means no borrow.
- Lock:
  - Set when the accepted op has lock=1; the owner is the granted id.
  - Cleared when the owner's accepted op has lock=0.
  - Requester valids and lock inputs are sampled only at handshake. Dropping valid while holding lock does not release it.
- Reset mid-operation: the in-flight op is discarded, no resp pulse is issued, and the next grant follows the reset pointer.
- Inputs of a requester without ready are ignored. Requesters must hold valid and operands stable until ready.

Decomposition:
- Shared package addsub_arb_pkg:
  - state enum {IDLE, EXEC, DONE}
  - requester id constants REQ0=0, REQ1=1
  - WIDTH constant 16
- Sub-module: the existing cla_16bit, instantiated once and fed from the operand registers. No new sub-module.

Test Plan:
- Add: req0 A=0x8000, B=0x4000, sub=0 at cycle 0 -> resp0_valid at cycle 2; result=0xC000, cout=0, ovfl=0, zero=0.
- Sub: req1 A=0x8000, B=0x4000, sub=1 -> result=0x4000, cout=1, ovfl=1, resp1_valid only.
- Zero/carry: req0 A=0xFFFF, B=0x0001, add -> result=0x0000, cout=1, zero=1, ovfl=0.
- Contention: both valid from reset with distinct ops, held high -> order is req0 then req1 then req0. Responses at cycles 2, 4 and 6, each pulsed on the correct resp line.
- Lock: req0 issues 3 ops, lock=1,1,0, while req1 is continuously valid -> req1_ready=0 until req0's third handshake. req1 is granted at the next grant point.
- Reset mid-op: assert rst_n=0 during EXEC -> outputs immediately 0, no resp pulse. After release, req0 is granted first when both are valid.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package addsub_arb_pkg;

   localparam int unsigned WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate.
module cla_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_cout
);

   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [16:0] w_c;
   logic [3:0]  w_gg;
   logic [3:0]  w_pg;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin
      w_c    = '0;
      w_gg   = '0;
      w_pg   = '0;
      w_c[0] = i_cin;
      for (int unsigned k = 0; k < 4; k++) begin
         w_gg[k] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
         w_pg[k] = &w_p[4*k +: 4];
         for (int unsigned i = 0; i < 3; i++) begin
            w_c[4*k+i+1] = w_g[4*k+i] | (w_p[4*k+i] & w_c[4*k+i]);
         end
         // Group carry-out skips the in-group ripple.
         w_c[4*k+4] = w_gg[k] | (w_pg[k] & w_c[4*k]);
      end
   end

   assign o_sum  = w_p ^ w_c[15:0];
   assign o_cout = w_c[16];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one cla_16bit between two valid/ready requesters.
module addsub_arbiter
   import addsub_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req0_lock,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   input  logic             req1_lock,
   output logic             resp0_valid,
   output logic             resp1_valid,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovfl,
   output logic             zero
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sub;
   logic             r_id;
   logic             r_last;
   logic             r_lock_act;
   logic             r_lock_own;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_ovfl;
   logic             r_zero;

   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_hs;
   logic             w_hs_id;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic             w_sel_sub;
   logic             w_sel_lock;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovfl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rdy0      = 1'b0;
      w_rdy1      = 1'b0;
      if (rst_n && (r_state != EXEC)) begin
         if (r_lock_act) begin
            if (r_lock_own == REQ0) w_rdy0 = req0_valid;
            else                    w_rdy1 = req1_valid;
         end else if (req0_valid && req1_valid) begin
            // Both pending: the one not granted last goes next.
            if (r_last == REQ0) w_rdy1 = 1'b1;
            else                w_rdy0 = 1'b1;
         end else begin
            w_rdy0 = req0_valid;
            w_rdy1 = req1_valid;
         end
      end
      w_hs    = w_rdy0 | w_rdy1;
      w_hs_id = w_rdy1 ? REQ1 : REQ0;
      case (r_state)
         IDLE, DONE: w_state_nxt = w_hs ? EXEC : IDLE;
         EXEC:       w_state_nxt = DONE;
         default:    w_state_nxt = IDLE;
      endcase
   end

   assign w_sel_a    = w_hs_id ? req1_a    : req0_a;
   assign w_sel_b    = w_hs_id ? req1_b    : req0_b;
   assign w_sel_sub  = w_hs_id ? req1_sub  : req0_sub;
   assign w_sel_lock = w_hs_id ? req1_lock : req0_lock;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a        <= '0;
         r_b        <= '0;
         r_sub      <= 1'b0;
         r_id       <= REQ0;
         r_last     <= REQ1;
         r_lock_act <= 1'b0;
         r_lock_own <= REQ0;
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_ovfl     <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         if (w_hs) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_sub  <= w_sel_sub;
            r_id   <= w_hs_id;
            r_last <= w_hs_id;
            if (w_sel_lock) begin
               r_lock_act <= 1'b1;
               r_lock_own <= w_hs_id;
            end else if (r_lock_act && (r_lock_own == w_hs_id)) begin
               r_lock_act <= 1'b0;
            end
         end
         if (r_state == EXEC) begin
            r_result <= w_sum;
            r_cout   <= w_cout;
            r_ovfl   <= w_ovfl;
            r_zero   <= (w_sum == '0);
         end
      end
   end

   assign w_b_eff = r_b ^ {WIDTH{r_sub}};

   cla_16bit u_cla (
      .i_a    (r_a),
      .i_b    (w_b_eff),
      .i_cin  (r_sub),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_ovfl = r_sub
      ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]))
      : ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]));

   assign req0_ready  = w_rdy0;
   assign req1_ready  = w_rdy1;
   assign resp0_valid = (r_state == DONE) && (r_id == REQ0);
   assign resp1_valid = (r_state == DONE) && (r_id == REQ1);
   assign result      = r_result;
   assign cout        = r_cout;
   assign ovfl        = r_ovfl;
   assign zero        = r_zero;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: vector table, random ops vs model, hand sequences.
module tb_addsub_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_sub = 1'b0, req0_lock = 1'b0;
   logic        req1_valid = 1'b0, req1_sub = 1'b0, req1_lock = 1'b0;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
   logic [15:0] result;
   logic        cout, ovfl, zero;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   addsub_arbiter #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_sub(req0_sub), .req0_lock(req0_lock),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_sub(req1_sub), .req1_lock(req1_lock),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .result(result), .cout(cout), .ovfl(ovfl), .zero(zero)
   );

   typedef struct {
      logic        id;
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, returns {zero, ovfl, cout, result}.
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      logic [16:0] u;
      int          sa, sb, sr;
      logic        c, v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         u  = {1'b0, a} - {1'b0, b};
         c  = (a >= b);
         sr = sa - sb;
      end else begin
         u  = {1'b0, a} + {1'b0, b};
         c  = u[16];
         sr = sa + sb;
      end
      v = (sr > 32767) || (sr < -32768);
      return {(u[15:0] == 16'h0), v, c, u[15:0]};
   endfunction

   task automatic set_req(input logic id, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic lock);
      if (id) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; req1_lock = lock;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; req0_lock = lock;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      chk("rst outputs", {resp0_valid, resp1_valid, result, cout, ovfl, zero}, '0);
      chk("rst ready", {req0_ready, req1_ready}, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called just after a negedge; returns just after the negedge of the DONE cycle.
   task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] er, input logic ec, input logic ev, input logic ez,
                        input string tag);
      int waits = 0;
      set_req(!id, 1'b0, '0, '0, 1'b0, 1'b0);
      set_req(id, 1'b1, a, b, sub, 1'b0);
      #1;
      while (!(id ? req1_ready : req0_ready) && waits < 10) begin
         @(negedge clk); #1;
         waits++;
      end
      chk({tag, " grant"}, id ? req1_ready : req0_ready, 1);
      @(negedge clk); #1;
      chk({tag, " exec ready"}, {req0_ready, req1_ready}, 0);
      chk({tag, " exec resp"}, {resp0_valid, resp1_valid}, 0);
      set_req(id, 1'b0, a, b, sub, 1'b0);
      @(negedge clk); #1;
      chk({tag, " resp"}, {resp0_valid, resp1_valid}, id ? 2'b01 : 2'b10);
      chk({tag, " result"}, result, er);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " ovfl"}, ovfl, ev);
      chk({tag, " zero"}, zero, ez);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[7];
      logic [3:0]  cexp[7];
      logic [3:0]  lexp[10];
      logic [9:0]  lv0, ll0, lv1;
      logic [15:0] ra, rb, last_r;
      logic        rs, rid;
      logic [18:0] m;

      vecs[0] = '{1'b0, 16'h8000, 16'h4000, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'h8000, 16'h4000, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 16'h7FFF, 16'h8000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};

      apply_reset();
      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub,
               vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z, $sformatf("vec%0d", i));
      end

      last_r = '0;
      for (int i = 0; i < 40; i++) begin
         rid = 1'($urandom_range(0, 1));
         rs  = 1'($urandom_range(0, 1));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
         if ($urandom_range(0, 5) == 0) ra = 16'h8000;
         m = model(ra, rb, rs);
         issue(rid, ra, rb, rs, m[15:0], m[16], m[17], m[18], $sformatf("rnd%0d", i));
         last_r = m[15:0];
      end

      repeat (3) @(negedge clk);
      #1;
      chk("hold result", result, last_r);
      chk("hold resp", {resp0_valid, resp1_valid}, 0);

      // Contention: both valid from reset, {ready0, ready1, resp0, resp1} per cycle.
      cexp = '{4'b1000, 4'b0000, 4'b0110, 4'b0000, 4'b1001, 4'b0000, 4'b0110};
      apply_reset();
      set_req(1'b0, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
      set_req(1'b1, 1'b1, 16'h0010, 16'h0001, 1'b1, 1'b0);
      for (int c = 0; c < 7; c++) begin
         #1;
         chk($sformatf("cont c%0d", c), {req0_ready, req1_ready, resp0_valid, resp1_valid}, cexp[c]);
         if (c == 2 || c == 6) chk($sformatf("cont res c%0d", c), result, 16'h0007);
         if (c == 4) chk("cont res c4", result, 16'h000F);
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      // Lock: req0 ops with lock 1,1,0 (valid dropped once while holding), req1 always valid.
      lv0  = 10'b0000101111;
      ll0  = 10'b0000001111;
      lv1  = 10'b0011111111;
      lexp = '{4'b1000, 4'b0000, 4'b1010, 4'b0000, 4'b0010,
               4'b1000, 4'b0000, 4'b0110, 4'b0000, 4'b0001};
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         set_req(1'b0, lv0[c], 16'h0001, 16'h0001, 1'b0, ll0[c]);
         set_req(1'b1, lv1[c], 16'h0100, 16'h0001, 1'b0, 1'b0);
         #1;
         chk($sformatf("lock c%0d", c), {req0_ready, req1_ready, resp0_valid, resp1_valid}, lexp[c]);
         if (c == 9) chk("lock res req1", result, 16'h0101);
         @(negedge clk);
      end

      // Reset during EXEC after a req0 grant: outputs clear, no pulse, pointer back to req0.
      issue(1'b1, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, "pre");
      set_req(1'b0, 1'b1, 16'h0005, 16'h0006, 1'b0, 1'b0);
      #1;
      chk("mid grant", req0_ready, 1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid outputs", {resp0_valid, resp1_valid, result, cout, ovfl, zero}, '0);
      set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("mid quiet c%0d", c), {resp0_valid, resp1_valid, result}, '0);
         @(negedge clk);
      end
      set_req(1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0);
      set_req(1'b1, 1'b1, 16'h0009, 16'h0001, 1'b0, 1'b0);
      #1;
      chk("mid ptr", {req0_ready, req1_ready}, 2'b10);
      @(negedge clk);
      set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("mid post resp", {resp0_valid, resp1_valid, result}, {2'b10, 16'h0004});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
